// File: rtl/hex_entry.sv
// hex_entry: button-driven hex editor for two 32-bit operands with nibble cursor, blink mask and up/down auto-repeat
module hex_entry #(
  parameter logic [31:0] INIT_A        = 32'h0000_0000,
  parameter logic [31:0] INIT_B        = 32'h0000_0000,
  parameter int          REPEAT_DELAY  = 50_000_000,
  parameter int          REPEAT_PERIOD = 10_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  btn_ok,
  input  logic        entry_en,
  input  logic        target_b,
  output logic [31:0] ai,
  output logic [31:0] bi,
  output logic [2:0]  cursor,
  output logic [7:0]  blink
);
  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;
  localparam logic [31:0] DLY_END = 32'(REPEAT_DELAY - 1);
  localparam logic [31:0] PER_END = 32'(REPEAT_PERIOD - 1);
  state_t      state_q, state_d;
  logic [31:0] ai_q, ai_d, bi_q, bi_d, rcnt_q, rcnt_d, tgt, upd;
  logic [4:0]  btn_prev_q, btn_prev_d, press, sh;
  logic [3:0]  nib;
  logic [2:0]  cursor_q, cursor_d;
  logic [7:0]  blink_q, blink_d;
  logic        dir_q, dir_d, step, step_up, clr;
  // press decode with C > L > R > U > D priority, auto-repeat sequencing and target nibble update
  always_comb begin
    press      = btn_ok & ~btn_prev_q;
    btn_prev_d = btn_ok;
    ai_d       = ai_q;
    bi_d       = bi_q;
    cursor_d   = cursor_q;
    state_d    = state_q;
    rcnt_d     = rcnt_q;
    dir_d      = dir_q;
    step       = 1'b0;
    step_up    = dir_q;
    clr        = 1'b0;
    if (!entry_en) begin
      state_d = IDLE;
      rcnt_d  = '0;
    end else if (press[0]) begin
      clr     = 1'b1;
      state_d = IDLE;
    end else if (press[4]) begin
      cursor_d = cursor_q + 3'd1;
      state_d  = IDLE;
    end else if (press[2]) begin
      cursor_d = cursor_q - 3'd1;
      state_d  = IDLE;
    end else if (press[3] | press[1]) begin
      step    = 1'b1;
      step_up = press[3];
      dir_d   = press[3];
      state_d = HOLD;
      rcnt_d  = '0;
    end else if (state_q != IDLE) begin
      if (!(dir_q ? btn_ok[3] : btn_ok[1])) begin
        state_d = IDLE;
        rcnt_d  = '0;
      end else if (rcnt_q == (state_q == HOLD ? DLY_END : PER_END)) begin
        step    = 1'b1;
        state_d = REPEAT;
        rcnt_d  = '0;
      end else begin
        rcnt_d = rcnt_q + 32'd1;
      end
    end
    tgt          = target_b ? bi_q : ai_q;
    sh           = {cursor_q, 2'b00};
    nib          = tgt[sh +: 4];
    upd          = tgt;
    upd[sh +: 4] = step_up ? nib + 4'd1 : nib - 4'd1;
    upd          = clr ? '0 : upd;
    ai_d         = (step | clr) && !target_b ? upd : ai_d;
    bi_d         = (step | clr) && target_b ? upd : bi_d;
    blink_d      = entry_en ? 8'b1 << cursor_d : 8'h00;
  end
  // state registers; btn_prev resets to all-ones so a button held through reset is not a press
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_prev_q <= 5'b11111;
      ai_q       <= INIT_A;
      bi_q       <= INIT_B;
      cursor_q   <= '0;
      blink_q    <= '0;
      state_q    <= IDLE;
      rcnt_q     <= '0;
      dir_q      <= 1'b0;
    end else begin
      btn_prev_q <= btn_prev_d;
      ai_q       <= ai_d;
      bi_q       <= bi_d;
      cursor_q   <= cursor_d;
      blink_q    <= blink_d;
      state_q    <= state_d;
      rcnt_q     <= rcnt_d;
      dir_q      <= dir_d;
    end
  end
  assign ai     = ai_q;
  assign bi     = bi_q;
  assign cursor = cursor_q;
  assign blink  = blink_q;
endmodule

// File: tb/tb_hex_entry.sv
// tb_hex_entry: directed vector table plus hand-written multi-cycle sequences for hex_entry
module tb_hex_entry;
  localparam logic [31:0] IA = 32'h1234_5678;
  localparam logic [4:0] B0 = 5'b00000, BC = 5'b00001, BD = 5'b00010, BR = 5'b00100, BU = 5'b01000, BL = 5'b10000;
  logic        clk = 1'b0, rst = 1'b1, entry_en = 1'b1, target_b = 1'b0;
  logic [4:0]  btn_ok = BU;
  logic [31:0] ai, bi;
  logic [2:0]  cursor;
  logic [7:0]  blink;
  int total = 0, bad = 0;

  typedef struct {
    logic [4:0]  btn;
    logic        en;
    logic        tb;
    logic [31:0] ea;
    logic [31:0] eb;
    logic [2:0]  ec;
    logic [7:0]  ebl;
  } vec_t;
  vec_t vecs[24];

  hex_entry #(.INIT_A(IA), .INIT_B(32'h0), .REPEAT_DELAY(4), .REPEAT_PERIOD(2)) dut (
    .clk(clk), .rst(rst), .btn_ok(btn_ok), .entry_en(entry_en), .target_b(target_b),
    .ai(ai), .bi(bi), .cursor(cursor), .blink(blink)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] ea, input logic [31:0] eb, input logic [2:0] ec, input logic [7:0] ebl);
    total++;
    if (ai !== ea || bi !== eb || cursor !== ec || blink !== ebl) begin
      bad++;
      $display("FAIL %s: got ai=%h bi=%h cursor=%0d blink=%h, want ai=%h bi=%h cursor=%0d blink=%h",
               name, ai, bi, cursor, blink, ea, eb, ec, ebl);
    end
  endtask

  initial begin
    vecs[0]  = '{BC, 1, 0, 32'h0,  32'h0,         0, 8'h01};
    vecs[1]  = '{B0, 1, 0, 32'h0,  32'h0,         0, 8'h01};
    vecs[2]  = '{BU, 1, 0, 32'h1,  32'h0,         0, 8'h01};
    vecs[3]  = '{B0, 1, 0, 32'h1,  32'h0,         0, 8'h01};
    vecs[4]  = '{BD, 1, 0, 32'h0,  32'h0,         0, 8'h01};
    vecs[5]  = '{B0, 1, 0, 32'h0,  32'h0,         0, 8'h01};
    vecs[6]  = '{BD, 1, 0, 32'hF,  32'h0,         0, 8'h01};
    vecs[7]  = '{B0, 1, 0, 32'hF,  32'h0,         0, 8'h01};
    vecs[8]  = '{BL, 1, 0, 32'hF,  32'h0,         1, 8'h02};
    vecs[9]  = '{B0, 1, 0, 32'hF,  32'h0,         1, 8'h02};
    vecs[10] = '{BU, 1, 0, 32'h1F, 32'h0,         1, 8'h02};
    vecs[11] = '{B0, 1, 0, 32'h1F, 32'h0,         1, 8'h02};
    vecs[12] = '{BR, 1, 0, 32'h1F, 32'h0,         0, 8'h01};
    vecs[13] = '{B0, 1, 0, 32'h1F, 32'h0,         0, 8'h01};
    vecs[14] = '{BR, 1, 0, 32'h1F, 32'h0,         7, 8'h80};
    vecs[15] = '{B0, 1, 0, 32'h1F, 32'h0,         7, 8'h80};
    vecs[16] = '{BU, 1, 1, 32'h1F, 32'h1000_0000, 7, 8'h80};
    vecs[17] = '{B0, 1, 1, 32'h1F, 32'h1000_0000, 7, 8'h80};
    vecs[18] = '{BL, 1, 1, 32'h1F, 32'h1000_0000, 0, 8'h01};
    vecs[19] = '{B0, 1, 1, 32'h1F, 32'h1000_0000, 0, 8'h01};
    vecs[20] = '{BU, 0, 0, 32'h1F, 32'h1000_0000, 0, 8'h00};
    vecs[21] = '{B0, 1, 0, 32'h1F, 32'h1000_0000, 0, 8'h01};
    vecs[22] = '{BC, 1, 1, 32'h1F, 32'h0,         0, 8'h01};
    vecs[23] = '{B0, 1, 0, 32'h1F, 32'h0,         0, 8'h01};

    // reset with U held: init values, and no step until U is released and re-pressed
    repeat (2) tick();
    chk("reset", IA, 32'h0, 0, 8'h00);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin tick(); chk("held_thru_reset", IA, 32'h0, 0, 8'h01); end
    btn_ok = B0; tick(); chk("release_after_reset", IA, 32'h0, 0, 8'h01);
    btn_ok = BU; tick(); chk("repress_after_reset", IA + 32'h1, 32'h0, 0, 8'h01);
    btn_ok = B0; tick();

    // single-step table
    for (int i = 0; i < 24; i++) begin
      btn_ok = vecs[i].btn; entry_en = vecs[i].en; target_b = vecs[i].tb;
      tick();
      chk($sformatf("vec%0d", i), vecs[i].ea, vecs[i].eb, vecs[i].ec, vecs[i].ebl);
    end

    // fill ai with F's: clear, then D at each nibble while walking left
    btn_ok = BC; tick(); btn_ok = B0; tick();
    for (int k = 0; k < 8; k++) begin
      btn_ok = BD; tick(); btn_ok = B0; tick();
      btn_ok = BL; tick(); btn_ok = B0; tick();
    end
    chk("all_f", 32'hFFFF_FFFF, 32'h0, 0, 8'h01);
    btn_ok = BC | BU; tick(); chk("c_plus_u", 32'h0, 32'h0, 0, 8'h01);
    for (int i = 0; i < 6; i++) begin tick(); chk("c_plus_u_no_repeat", 32'h0, 32'h0, 0, 8'h01); end
    btn_ok = B0; tick();

    // auto-repeat: steps at P, P+4, P+6, P+8 then nothing after release
    btn_ok = BU;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("repeat_k%0d", k), 32'(1 + (k >= 4 ? (k - 4) / 2 + 1 : 0)), 32'h0, 0, 8'h01);
    end
    btn_ok = B0;
    for (int i = 0; i < 4; i++) begin tick(); chk("after_release", 32'h4, 32'h0, 0, 8'h01); end

    // disable during REPEAT, then re-enable with U still held
    btn_ok = BU;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("en_k%0d", k), k >= 4 ? 32'h6 : 32'h5, 32'h0, 0, 8'h01);
    end
    entry_en = 1'b0;
    for (int i = 0; i < 4; i++) begin tick(); chk("disabled", 32'h6, 32'h0, 0, 8'h00); end
    entry_en = 1'b1;
    for (int i = 0; i < 6; i++) begin tick(); chk("reenabled_held", 32'h6, 32'h0, 0, 8'h01); end
    btn_ok = B0; tick();

    // target toggle during HOLD redirects the repeat step to bi
    btn_ok = BU; tick(); chk("tgl_first", 32'h7, 32'h0, 0, 8'h01);
    for (int i = 0; i < 3; i++) begin tick(); chk("tgl_hold", 32'h7, 32'h0, 0, 8'h01); end
    target_b = 1'b1; tick(); chk("tgl_step_b", 32'h7, 32'h1, 0, 8'h01);
    btn_ok = B0; target_b = 1'b0; tick();

    // async reset mid-hold takes effect without a clock edge
    btn_ok = BU; tick(); chk("pre_async", 32'h8, 32'h1, 0, 8'h01);
    rst = 1'b1; #1;
    chk("async_rst", IA, 32'h0, 0, 8'h00);
    #2 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin tick(); chk("held_after_async", IA, 32'h0, 0, 8'h01); end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
